fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Queue entries carry the PC at full 64-bit width; narrower PCs are zero-extended.
package fetch_pkg;

    localparam int INST_W   = 32;
    localparam int PC_STEP  = 4;
    localparam int PC_W_MAX = 64;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [INST_W-1:0]   inst;
    } fq_entry_t;

    // Instructions are word aligned, so redirect targets drop their low two bits.
    function automatic logic [PC_W_MAX-1:0] align_target(input logic [PC_W_MAX-1:0] target);
        return target & ~PC_W_MAX'(2'b11);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instruction} pairs between fetch and decode.
// Flush empties the queue in one edge and overrides any push or pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fq_entry_t        wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fq_entry_t        head_o
);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        // A pop in the same cycle frees a slot, so a full queue can still accept.
        push_ok  = push_i & ~flush_i & (~full_o | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, samples the instruction cache and
// queues {pc, instruction} pairs for decode; redirects flush and refetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_en,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [INST_W-1:0]           imem_data,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [INST_W-1:0]           dec_inst,
    output logic [PC_W-1:0]             dec_pc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W_MAX-1:0] target_ext;
    logic                push, pop, full, empty;
    fq_entry_t           wr_entry, head;

    assign imem_addr = pc_q;
    assign dec_valid = ~empty;
    assign pop       = dec_valid & dec_ready;
    // Redirect outranks fetch: nothing from the stale path enters the queue.
    assign push      = fetch_en & ~redirect_valid & (~full | pop);
    assign dec_inst  = head.inst;
    assign dec_pc    = head.pc[PC_W-1:0];

    always_comb begin
        target_ext                = '0;
        target_ext[PC_W-1:0]      = redirect_pc;
        wr_entry                  = '0;
        wr_entry.pc[PC_W-1:0]     = pc_q;
        wr_entry.inst             = imem_data;
        pc_d                      = pc_q;
        if (redirect_valid) begin
            pc_d = PC_W'(align_target(target_ext));
        end else if (push) begin
            pc_d = pc_q + PC_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fq_count),
        .head_o  (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue-based model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_en, redirect_valid, dec_ready;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr, dec_pc;
    logic [31:0] imem_data, dec_inst;
    logic        dec_valid;
    logic [2:0]  fq_count;

    logic        w_fetch_en, w_redirect_valid, w_dec_ready;
    logic [63:0] w_redirect_pc;
    logic [63:0] w_imem_addr, w_dec_pc;
    logic [31:0] w_imem_data, w_dec_inst;
    logic        w_dec_valid;
    logic [2:0]  w_fq_count;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] cache_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h1111_1111;
            64'h4:   return 32'h2222_2222;
            64'h8:   return 32'h3333_3333;
            default: return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign imem_data   = cache_word(imem_addr);
    assign w_imem_data = cache_word(w_imem_addr);

    fetch_unit #(.PC_W(64), .RESET_PC(64'h0), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .fq_count(fq_count)
    );

    fetch_unit #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FQ_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(w_fetch_en), .imem_addr(w_imem_addr),
        .imem_data(w_imem_data), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .dec_valid(w_dec_valid), .dec_ready(w_dec_ready), .dec_inst(w_dec_inst),
        .dec_pc(w_dec_pc), .fq_count(w_fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        w_fetch_en = 1'b0; w_dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        do_rst;
        logic        fe, rv, rdy;
        logic [63:0] rpc;
        logic [63:0] e_addr;
        logic        e_valid;
        int          e_count;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic fe, input logic rv, input logic [63:0] rpc,
                       input logic rdy, input logic [63:0] ea, input logic ev, input int ec,
                       input logic [63:0] ep);
        vec_t v;
        v.do_rst = r; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_addr = ea; v.e_valid = ev; v.e_count = ec; v.e_pc = ep;
        vt.push_back(v);
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;

    initial begin
        reset = 1'b1;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        w_fetch_en = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_dec_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst imem_addr", imem_addr, 64'h0);
        chk("rst dec_valid", 64'(dec_valid), 64'h0);
        chk("rst fq_count", 64'(fq_count), 64'h0);
        chk("rst dec_inst", 64'(dec_inst), 64'h0);
        chk("rst dec_pc", dec_pc, 64'h0);
        chk("rst wrap imem_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // Streaming
        add(1, 1, 0, 0, 1,   0, 0, 0, 0);
        add(0, 1, 0, 0, 1,   4, 1, 1, 0);
        add(0, 1, 0, 0, 1,   8, 1, 1, 4);
        add(0, 0, 0, 0, 1,  12, 1, 1, 8);
        add(0, 0, 0, 0, 0,  12, 0, 0, 0);
        // Backpressure up to full, then push and pop on a full queue
        add(1, 1, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   4, 1, 1, 0);
        add(0, 1, 0, 0, 0,   8, 1, 2, 0);
        add(0, 1, 0, 0, 0,  12, 1, 3, 0);
        add(0, 1, 0, 0, 0,  16, 1, 4, 0);
        add(0, 1, 0, 0, 0,  16, 1, 4, 0);
        add(0, 1, 0, 0, 1,  16, 1, 4, 0);
        add(0, 1, 0, 0, 0,  20, 1, 4, 4);
        add(0, 0, 0, 0, 1,  20, 1, 4, 4);
        // Redirect with 3 queued, then redirect colliding with pop and fetch
        add(0, 0, 1, 64'h102, 0,  20,      1, 3, 8);
        add(0, 1, 0, 0, 1,        64'h100, 0, 0, 0);
        add(0, 1, 0, 0, 1,        64'h104, 1, 1, 64'h100);
        add(0, 1, 1, 64'h207, 1,  64'h108, 1, 1, 64'h104);
        add(0, 1, 0, 0, 0,        64'h204, 0, 0, 0);
        add(0, 0, 0, 0, 0,        64'h208, 1, 1, 64'h204);
        // fetch_en gating: queue drains, pc holds, then fetch resumes
        add(0, 0, 0, 0, 1,  64'h208, 1, 1, 64'h204);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 64'h208, 0, 0, 0);
        add(0, 1, 0, 0, 1,  64'h208, 0, 0, 0);
        add(0, 1, 0, 0, 1,  64'h20C, 1, 1, 64'h208);

        foreach (vt[i]) begin
            if (vt[i].do_rst) do_reset();
            fetch_en = vt[i].fe; redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc; dec_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d dec_valid", i), 64'(dec_valid), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d fq_count", i), 64'(fq_count), 64'(vt[i].e_count));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d dec_pc", i), dec_pc, vt[i].e_pc);
                chk($sformatf("vec%0d dec_inst", i), 64'(dec_inst), 64'(cache_word(vt[i].e_pc)));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a cycle with 3 entries queued
        do_reset();
        fetch_en = 1'b1; dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 fetch_en = 1'b0;
        @(negedge clk);
        chk("midrst count before", 64'(fq_count), 64'h3);
        #2 reset = 1'b1;
        #1;
        chk("midrst fq_count", 64'(fq_count), 64'h0);
        chk("midrst dec_valid", 64'(dec_valid), 64'h0);
        chk("midrst imem_addr", imem_addr, 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // PC wrap from all-ones to zero
        do_reset();
        w_fetch_en = 1'b1; w_dec_ready = 1'b1;
        @(negedge clk);
        chk("wrap addr0", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap addr1", w_imem_addr, 64'h0);
        chk("wrap first dec_pc", w_dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap second valid", 64'(w_dec_valid), 64'h1);
        chk("wrap second dec_pc", w_dec_pc, 64'h0);
        chk("wrap second dec_inst", 64'(w_dec_inst), 64'(cache_word(64'h0)));
        w_fetch_en = 1'b0; w_dec_ready = 1'b0;

        // Randomized run against the queue model; exercises pointer wrap and ordering
        do_reset();
        m_pc = 64'h0;
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            logic fe, rv, rdy;
            logic [63:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            rv  = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            rpc = {$urandom, $urandom};
            fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
            @(negedge clk);
            chk($sformatf("rnd%0d imem_addr", n), imem_addr, m_pc);
            chk($sformatf("rnd%0d dec_valid", n), 64'(dec_valid), 64'(mq.size() != 0));
            chk($sformatf("rnd%0d fq_count", n), 64'(fq_count), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk($sformatf("rnd%0d dec_pc", n), dec_pc, mq[0].pc);
                chk($sformatf("rnd%0d dec_inst", n), 64'(dec_inst), 64'(mq[0].inst));
            end
            @(posedge clk);
            if (rv) begin
                mq.delete();
                m_pc = rpc & ~64'h3;
            end else begin
                if (mq.size() != 0 && rdy) void'(mq.pop_front());
                if (fe && mq.size() < DEPTH) begin
                    ent_t e;
                    e.pc = m_pc;
                    e.inst = cache_word(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
